// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Imported by the FIFO, the interface, the top and the bench.
package regfile_wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DEPTH  = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback source handshakes, register-file write port and hazard mask.
// The master side is driven by the sources, the slave side by the arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
);

    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   alu_ready;

    logic                   lsu_valid;
    logic [ADDR_W-1:0]      lsu_rd;
    logic [DATA_W-1:0]      lsu_data;
    logic                   lsu_ready;

    logic [ADDR_W-1:0]      rdi;
    logic [DATA_W-1:0]      write_data;
    logic                   reg_write;
    logic [2**ADDR_W-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rdi, write_data, reg_write, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rdi, write_data, reg_write, pending_mask
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback entries; exposes every slot's
// occupancy and destination so the top can build the hazard mask.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             push_rd,
    input  logic [DATA_W-1:0]             push_data,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_W-1:0]             head_rd,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PW-1:0]                rptr;
    logic [PW-1:0]                wptr;
    logic [PW:0]                  cnt;
    logic                         do_push;
    logic                         do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_rd   = rd_q[rptr];
    assign head_data = data_q[rptr];
    assign ent_rd    = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            data_q <= '0;
            rptr   <= '0;
            wptr   <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                rd_q[wptr]   <= push_rd;
                data_q[wptr] <= push_data;
                wptr         <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (PW+1)'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - (PW+1)'(1);
            end
        end
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = ({1'b0, PW'(i) - rptr} < cnt);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU and LSU writeback queues, with a pending-write hazard mask.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int NREG = 2**ADDR_W;

    logic                         a_full, a_empty, a_push, a_pop, a_rdy;
    logic                         l_full, l_empty, l_push, l_pop, l_rdy;
    logic [ADDR_W-1:0]            a_hrd, l_hrd;
    logic [DATA_W-1:0]            a_hdata, l_hdata;
    logic [DEPTH-1:0]             a_ev, l_ev;
    logic [DEPTH-1:0][ADDR_W-1:0] a_erd, l_erd;

    logic                         last_q, last_d;
    logic                         we_q;
    logic [ADDR_W-1:0]            rd_q;
    logic [DATA_W-1:0]            data_q;
    logic [NREG-1:0]              mask;

    assign a_rdy = rst_n && !a_full;
    assign l_rdy = rst_n && !l_full;

    // x0 transfers complete the handshake but never enter a queue.
    assign a_push = bus.alu_valid && a_rdy && (bus.alu_rd != '0);
    assign l_push = bus.lsu_valid && l_rdy && (bus.lsu_rd != '0);

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .pop       (a_pop),
        .push_rd   (bus.alu_rd),
        .push_data (bus.alu_data),
        .full      (a_full),
        .empty     (a_empty),
        .head_rd   (a_hrd),
        .head_data (a_hdata),
        .ent_valid (a_ev),
        .ent_rd    (a_erd)
    );

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (l_push),
        .pop       (l_pop),
        .push_rd   (bus.lsu_rd),
        .push_data (bus.lsu_data),
        .full      (l_full),
        .empty     (l_empty),
        .head_rd   (l_hrd),
        .head_data (l_hdata),
        .ent_valid (l_ev),
        .ent_rd    (l_erd)
    );

    // The pointer only moves on contested grants; a lone source never
    // steals the other's next turn.
    always_comb begin
        a_pop  = 1'b0;
        l_pop  = 1'b0;
        last_d = last_q;
        unique case (1'b1)
            (!a_empty && !l_empty): begin
                if (last_q == SRC_ALU) begin
                    l_pop  = 1'b1;
                    last_d = SRC_LSU;
                end else begin
                    a_pop  = 1'b1;
                    last_d = SRC_ALU;
                end
            end
            (!a_empty && l_empty): a_pop = 1'b1;
            (a_empty && !l_empty): l_pop = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_LSU;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= a_pop || l_pop;
            if (a_pop) begin
                rd_q   <= a_hrd;
                data_q <= a_hdata;
            end else if (l_pop) begin
                rd_q   <= l_hrd;
                data_q <= l_hdata;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ev[i]) mask[a_erd[i]] = 1'b1;
            if (l_ev[i]) mask[l_erd[i]] = 1'b1;
        end
        if (we_q) mask[rd_q] = 1'b1;
    end

    assign bus.alu_ready    = a_rdy;
    assign bus.lsu_ready    = l_rdy;
    assign bus.reg_write    = we_q;
    assign bus.rdi          = rd_q;
    assign bus.write_data   = data_q;
    assign bus.pending_mask = mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random stress,
// all checked against a queue-level reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DW    = WB_DATA_W;
    localparam int AW    = WB_ADDR_W;
    localparam int DEPTH = WB_DEPTH;
    localparam int NREG  = 2**AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    regfile_wb_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-source queues, one staged write, and who won
    // the most recent contested grant.
    wb_entry_t aq[$];
    wb_entry_t lq[$];
    wb_entry_t st;
    bit        st_v;
    bit        alu_won_last;
    int        n_acc;
    int        dut_wr;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (aq[i]) m[aq[i].rd] = 1'b1;
        foreach (lq[i]) m[lq[i].rd] = 1'b1;
        if (st_v) m[st.rd] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        aq.delete();
        lq.delete();
        st           = '0;
        st_v         = 1'b0;
        alu_won_last = 1'b0;
        n_acc        = 0;
        dut_wr       = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit av, input logic [AW-1:0] ard,
                        input logic [DW-1:0] ad, input bit lv,
                        input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
        bit a_acc, l_acc, a_ne, l_ne, take_alu;
        bif.alu_valid = av;
        bif.alu_rd    = ard;
        bif.alu_data  = ad;
        bif.lsu_valid = lv;
        bif.lsu_rd    = lrd;
        bif.lsu_data  = ld;
        #1;
        check("alu_ready", bif.alu_ready, aq.size() < DEPTH);
        check("lsu_ready", bif.lsu_ready, lq.size() < DEPTH);
        a_acc = av && (aq.size() < DEPTH);
        l_acc = lv && (lq.size() < DEPTH);
        a_ne  = aq.size() != 0;
        l_ne  = lq.size() != 0;
        @(posedge clk);
        st_v = a_ne || l_ne;
        if (a_ne && l_ne) begin
            take_alu     = !alu_won_last;
            alu_won_last = take_alu;
        end else begin
            take_alu = a_ne;
        end
        if (st_v) st = take_alu ? aq.pop_front() : lq.pop_front();
        if (a_acc && ard != '0) begin
            aq.push_back('{rd: ard, data: ad});
            n_acc++;
        end
        if (l_acc && lrd != '0) begin
            lq.push_back('{rd: lrd, data: ld});
            n_acc++;
        end
        @(negedge clk);
        if (bif.reg_write) dut_wr++;
        check("reg_write", bif.reg_write, st_v);
        check("rdi", bif.rdi, st.rd);
        check("write_data", bif.write_data, st.data);
        check("pending_mask", bif.pending_mask, model_mask());
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        bit saw_full;
        logic [AW-1:0] r_a, r_l;

        bif.alu_valid = 1'b0;
        bif.alu_rd    = '0;
        bif.alu_data  = '0;
        bif.lsu_valid = 1'b0;
        bif.lsu_rd    = '0;
        bif.lsu_data  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_alu_ready", bif.alu_ready, 1'b0);
        check("rst_lsu_ready", bif.lsu_ready, 1'b0);
        check("rst_reg_write", bif.reg_write, 1'b0);
        check("rst_rdi", bif.rdi, 0);
        check("rst_mask", bif.pending_mask, 0);
        rst_n = 1'b1;

        // Single uncontested write and its mask lifetime.
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0);
        check("t1_mask_n1", bif.pending_mask, 32'h0000_0020);
        check("t1_we_n1", bif.reg_write, 1'b0);
        idle();
        check("t1_we_n2", bif.reg_write, 1'b1);
        check("t1_rdi_n2", bif.rdi, 5);
        check("t1_data_n2", bif.write_data, 32'h1234_5678);
        check("t1_mask_n2", bif.pending_mask, 32'h0000_0020);
        idle();
        check("t1_we_n3", bif.reg_write, 1'b0);
        check("t1_mask_n3", bif.pending_mask, 0);

        // Round-robin across two simultaneous pairs.
        step(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        idle();
        check("t2_first_rd", bif.rdi, 3);
        check("t2_first_data", bif.write_data, 32'hAAAA);
        idle();
        check("t2_second_rd", bif.rdi, 7);
        step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd8, 32'h8888);
        idle();
        check("t2_third_rd", bif.rdi, 8);
        idle();
        check("t2_fourth_rd", bif.rdi, 4);
        idle();

        // Back-to-back pushes from both sources fill the ALU queue.
        saw_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, AW'(10 + k), DW'(k), 1'b1, AW'(20 + k), DW'(100 + k));
            if (!bif.alu_ready) saw_full = 1'b1;
        end
        check("t3_alu_full_seen", saw_full, 1'b1);
        repeat (8) idle();

        // x0 from the LSU is accepted and dropped.
        check("t4_lsu_ready", bif.lsu_ready, 1'b1);
        step(1'b0, '0, '0, 1'b1, '0, 32'hFFFF_FFFF);
        check("t4_mask0", bif.pending_mask, 0);
        check("t4_we0", bif.reg_write, 1'b0);
        idle();
        check("t4_mask1", bif.pending_mask, 0);
        check("t4_we1", bif.reg_write, 1'b0);

        // Asynchronous reset with queued and staged writes.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, AW'(1 + k), DW'(32'h5000 + k), 1'b1, AW'(9 + k), DW'(32'h6000 + k));
        end
        check("t5_pre_we", bif.reg_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_we", bif.reg_write, 1'b0);
        check("t5_mask", bif.pending_mask, 0);
        check("t5_alu_ready", bif.alu_ready, 1'b0);
        check("t5_lsu_ready", bif.lsu_ready, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle();
        check("t5_no_stale", dut_wr, 0);

        // Random stress.
        model_reset();
        for (int c = 0; c < 10000; c++) begin
            r_a = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
            r_l = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
            step($urandom_range(0, 99) < 60, r_a, DW'($urandom),
                 $urandom_range(0, 99) < 60, r_l, DW'($urandom));
        end
        repeat (8) idle();
        check("stress_write_count", dut_wr, n_acc);
        check("stress_drained_mask", bif.pending_mask, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
